// File: rtl/countdown_display.sv
// Four-digit BCD countdown/up-counter with an SPI refresh loop that streams one
// {addr, digit} frame per digit to an external display driver.
module countdown_display #(
    parameter int TICK_DIV = 1000,
    parameter int SCLK_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_set,
    input  logic [15:0] i_in,
    input  logic        i_start,
    input  logic [1:0]  i_mode,
    output logic        o_ss,
    output logic        o_mosi,
    input  logic        i_miso,
    output logic        o_sclk,
    output logic [5:0]  o_state
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ASSERT  = 2'b01,
        S_SHIFT   = 2'b10,
        S_RELEASE = 2'b11
    } spi_t;

    // Clamp each digit to 9; in MM:SS mode the tens digits are capped at 5.
    function automatic logic [15:0] clamp(input logic [15:0] v, input logic mmss);
        logic [15:0] r;
        logic [3:0]  dg;
        r = v;
        for (int k = 0; k < 4; k++) begin
            dg = v[k*4 +: 4];
            if (dg > 4'd9) dg = 4'd9;
            if (mmss && (k == 1 || k == 3) && dg > 4'd5) dg = 4'd5;
            r[k*4 +: 4] = dg;
        end
        return r;
    endfunction

    // One BCD step with ripple carry/borrow; d1 wraps at 5 for seconds.
    function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic up,
                                             input logic mmss);
        logic [15:0] r;
        logic        c;
        logic [3:0]  dg;
        logic [3:0]  top;
        r = v;
        c = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dg  = r[k*4 +: 4];
            top = (mmss && k == 1) ? 4'd5 : 4'd9;
            if (c) begin
                if (up) begin
                    if (dg >= top) dg = 4'd0;
                    else begin dg = dg + 4'd1; c = 1'b0; end
                end else begin
                    if (dg == 4'd0) dg = top;
                    else begin dg = dg - 4'd1; c = 1'b0; end
                end
            end
            r[k*4 +: 4] = dg;
        end
        return r;
    endfunction

    logic          r_set_d;
    logic          r_alive;
    logic          r_done;
    logic [15:0]   r_cnt;
    logic [15:0]   r_limit;
    logic [PW-1:0] r_presc;

    logic          w_load;
    logic          w_cnt_en;
    logic          w_tick;
    logic [15:0]   w_clamped;
    logic [15:0]   w_next;
    logic          w_reached;
    logic          w_running;
    logic          w_unused;

    assign w_unused  = i_miso;
    assign w_load    = i_set & ~r_set_d;
    assign w_cnt_en  = i_start & ~r_done;
    assign w_tick    = w_cnt_en && (r_presc == PW'(TICK_DIV - 1));
    assign w_clamped = clamp(i_in, i_mode == 2'b10);
    assign w_running = r_alive & i_start & ~r_done & (i_mode != 2'b11);

    always_comb begin
        w_next = r_cnt;
        case (i_mode)
            2'b00:   w_next = bcd_step(r_cnt, 1'b0, 1'b0);
            2'b01:   w_next = bcd_step(r_cnt, 1'b1, 1'b0);
            2'b10:   w_next = bcd_step(r_cnt, 1'b0, 1'b1);
            default: w_next = r_cnt;
        endcase
        w_reached = (i_mode == 2'b01) ? (w_next == r_limit) : (w_next == 16'h0000);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_set_d <= 1'b0;
            r_alive <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= 16'h0000;
            r_limit <= 16'h0000;
            r_presc <= '0;
        end else begin
            r_set_d <= i_set;
            r_alive <= 1'b1;
            if (w_load) begin
                r_cnt   <= (i_mode == 2'b01) ? 16'h0000 : w_clamped;
                r_limit <= w_clamped;
                r_done  <= (i_mode != 2'b11) && (w_clamped == 16'h0000);
                r_presc <= '0;
            end else if (w_tick) begin
                r_presc <= '0;
                if (i_mode != 2'b11) begin
                    r_cnt  <= w_next;
                    r_done <= w_reached;
                end
            end else if (w_cnt_en) begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    spi_t          r_spi;
    spi_t          w_spi_nxt;
    logic [DW-1:0] r_div;
    logic [3:0]    r_bit;
    logic          r_sclk;
    logic [15:0]   r_shift;
    logic [1:0]    r_digit;
    logic          w_half;
    logic [3:0]    w_digit_val;

    assign w_half      = (r_div == DW'(SCLK_DIV - 1));
    assign w_digit_val = r_cnt[r_digit*4 +: 4];

    always_comb begin
        w_spi_nxt = r_spi;
        case (r_spi)
            S_IDLE:    w_spi_nxt = S_ASSERT;
            S_ASSERT:  if (w_half) w_spi_nxt = S_SHIFT;
            S_SHIFT:   if (w_half && r_sclk && r_bit == 4'd15) w_spi_nxt = S_RELEASE;
            S_RELEASE: if (w_half) w_spi_nxt = S_IDLE;
            default:   w_spi_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_spi <= S_IDLE;
        else        r_spi <= w_spi_nxt;
    end

    // Frame contents are latched in IDLE so a mid-frame tick shows up next frame.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_div   <= '0;
            r_bit   <= 4'd0;
            r_sclk  <= 1'b0;
            r_shift <= 16'h0000;
            r_digit <= 2'd0;
        end else begin
            r_div <= (w_half || r_spi != w_spi_nxt) ? '0 : r_div + DW'(1);
            case (r_spi)
                S_IDLE: begin
                    r_shift <= {4'b0000, {2'b00, r_digit} + 4'd1, 4'b0000, w_digit_val};
                    r_bit   <= 4'd0;
                    r_sclk  <= 1'b0;
                end
                S_SHIFT: begin
                    if (w_half) begin
                        r_sclk <= ~r_sclk;
                        if (r_sclk) begin
                            r_shift <= {r_shift[14:0], 1'b0};
                            r_bit   <= r_bit + 4'd1;
                        end
                    end
                end
                S_RELEASE: if (w_half) r_digit <= r_digit + 2'd1;
                default: ;
            endcase
        end
    end

    assign o_ss    = ~(r_spi == S_ASSERT || r_spi == S_SHIFT);
    assign o_mosi  = (r_spi == S_ASSERT || r_spi == S_SHIFT) ? r_shift[15] : 1'b0;
    assign o_sclk  = r_sclk;
    assign o_state = {w_running, r_done, r_digit, r_spi};

endmodule

// File: tb/tb_countdown_display.sv
// Directed bench for countdown_display: loads values, steps ticks, and reads the
// counter back by decoding the SPI refresh frames.
module tb_countdown_display;
    localparam int TD = 16;
    localparam int SD = 2;

    logic        clk = 1'b0, rst = 1'b0, set = 1'b0, start = 1'b0, miso = 1'b0;
    logic [15:0] in = 16'h0000;
    logic [1:0]  mode = 2'b00;
    logic        ss, mosi, sclk;
    logic [5:0]  st;

    countdown_display #(.TICK_DIV(TD), .SCLK_DIV(SD)) dut (
        .i_clk(clk), .i_rst(rst), .i_set(set), .i_in(in), .i_start(start),
        .i_mode(mode), .o_ss(ss), .o_mosi(mosi), .i_miso(miso), .o_sclk(sclk),
        .o_state(st)
    );

    always #5 clk = ~clk;

    int nvec = 0, nbad = 0;

    // SPI receiver: bits sampled on sclk rise while ss low, frame pushed on ss rise.
    logic [15:0] fq[$];
    logic [15:0] sh = 16'h0000;
    int          nb = 0;
    always @(negedge ss) begin nb = 0; sh = 16'h0000; end
    always @(posedge sclk) if (ss === 1'b0) begin sh = {sh[14:0], mosi}; nb++; end
    always @(posedge ss) if (nb == 16) begin fq.push_back(sh); nb = 0; end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_cnt(output logic [15:0] v);
        int t;
        logic fmt_bad;
        v = 16'hxxxx;
        t = 0;
        @(negedge clk);
        while (st[3:0] !== 4'd0 && t < 400) begin @(negedge clk); t++; end
        if (t >= 400) begin
            nvec++; nbad++;
            $display("FAIL read_sync: no digit-0 frame start seen, expected one within 400 cycles");
            return;
        end
        fq.delete();
        t = 0;
        while (fq.size() < 4 && t < 400) begin @(negedge clk); t++; end
        if (fq.size() < 4) begin
            nvec++; nbad++;
            $display("FAIL read_frames: got %0d frames expected 4", fq.size());
            return;
        end
        fmt_bad = 1'b0;
        v = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            if (fq[k][15:4] !== {4'h0, 4'(k + 1), 4'h0}) fmt_bad = 1'b1;
            v[k*4 +: 4] = fq[k][3:0];
        end
        chk("frame_fmt", {31'd0, fmt_bad}, 32'd0);
    endtask

    task automatic do_load(input logic [1:0] m, input logic [15:0] d);
        @(negedge clk);
        mode = m; in = d; set = 1'b1;
        @(negedge clk);
        set = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        @(negedge clk);
        start = 1'b1;
        repeat (n * TD) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [15:0] d;
        logic [15:0] ld;
        logic        ldone;
        int          nt;
        logic [15:0] q;
        logic        qdone;
    } vec_t;

    vec_t        tv[14];
    logic [15:0] v;
    int          t;

    initial begin
        tv[0]  = '{2'b00, 16'h3210, 16'h3210, 1'b0,  1, 16'h3209, 1'b0};
        tv[1]  = '{2'b00, 16'h3A1B, 16'h3919, 1'b0,  1, 16'h3918, 1'b0};
        tv[2]  = '{2'b00, 16'h1000, 16'h1000, 1'b0,  1, 16'h0999, 1'b0};
        tv[3]  = '{2'b01, 16'h0002, 16'h0000, 1'b0,  3, 16'h0002, 1'b1};
        tv[4]  = '{2'b01, 16'h0015, 16'h0000, 1'b0, 10, 16'h0010, 1'b0};
        tv[5]  = '{2'b10, 16'h9678, 16'h5658, 1'b0,  1, 16'h5657, 1'b0};
        tv[6]  = '{2'b10, 16'h5500, 16'h5500, 1'b0,  1, 16'h5459, 1'b0};
        tv[7]  = '{2'b10, 16'h0100, 16'h0100, 1'b0,  1, 16'h0059, 1'b0};
        tv[8]  = '{2'b11, 16'h1658, 16'h1658, 1'b0,  5, 16'h1658, 1'b0};
        tv[9]  = '{2'b00, 16'h0000, 16'h0000, 1'b1,  1, 16'h0000, 1'b1};
        tv[10] = '{2'b01, 16'h0000, 16'h0000, 1'b1,  1, 16'h0000, 1'b1};
        tv[11] = '{2'b00, 16'h0001, 16'h0001, 1'b0,  1, 16'h0000, 1'b1};
        tv[12] = '{2'b00, 16'hFFFF, 16'h9999, 1'b0,  1, 16'h9998, 1'b0};
        tv[13] = '{2'b10, 16'h1000, 16'h1000, 1'b0,  1, 16'h0959, 1'b0};

        // Reset state, with start high to confirm running is masked.
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {23'd0, ss, mosi, sclk, st}, {23'd0, 1'b1, 1'b0, 1'b0, 6'd0});
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("post_reset_frame_start", {29'd0, ss, st[3:2]}, 32'd0);

        // Set and start rise together; start dropped before the first tick.
        @(negedge clk);
        mode = 2'b00; in = 16'h3210; set = 1'b1; start = 1'b1;
        @(negedge clk);
        set = 1'b0; start = 1'b0;
        read_cnt(v);
        chk("joint_load", {16'd0, v}, 32'h3210);
        run_ticks(1);
        read_cnt(v);
        chk("joint_tick", {16'd0, v}, 32'h3209);

        foreach (tv[i]) begin
            do_load(tv[i].m, tv[i].d);
            read_cnt(v);
            chk($sformatf("v%0d_load", i), {16'd0, v}, {16'd0, tv[i].ld});
            chk($sformatf("v%0d_load_done", i), {31'd0, st[4]}, {31'd0, tv[i].ldone});
            run_ticks(tv[i].nt);
            read_cnt(v);
            chk($sformatf("v%0d_tick", i), {16'd0, v}, {16'd0, tv[i].q});
            chk($sformatf("v%0d_tick_done", i), {31'd0, st[4]}, {31'd0, tv[i].qdone});
        end

        // Running flag while counting, and masked in hold mode.
        do_load(2'b00, 16'h0005);
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        chk("running_on", {31'd0, st[5]}, 32'd1);
        mode = 2'b11;
        #1;
        chk("running_hold", {31'd0, st[5]}, 32'd0);
        start = 1'b0;

        // Mode change keeps contents; next tick uses the new mode.
        do_load(2'b00, 16'h0100);
        @(negedge clk); mode = 2'b01;
        read_cnt(v);
        chk("mode_switch_keep", {16'd0, v}, 32'h0100);
        run_ticks(1);
        read_cnt(v);
        chk("mode_switch_tick", {16'd0, v}, 32'h0101);

        // Held set must not reload after reaching zero.
        @(negedge clk);
        mode = 2'b00; in = 16'h0001; set = 1'b1;
        @(negedge clk);
        run_ticks(1);
        @(negedge clk);
        start = 1'b1; in = 16'h5555;
        @(negedge clk);
        chk("done_running_off", {31'd0, st[5]}, 32'd0);
        repeat (3 * TD) @(negedge clk);
        start = 1'b0;
        read_cnt(v);
        chk("held_set_no_reload", {16'd0, v}, 32'h0000);
        chk("held_set_done", {31'd0, st[4]}, 32'd1);
        set = 1'b0;

        // Reset in the middle of a frame aborts it immediately.
        do_load(2'b00, 16'h4321);
        t = 0;
        while (ss !== 1'b0 && t < 200) begin @(negedge clk); t++; end
        repeat (5) @(negedge clk);
        chk("midframe_ss_low", {31'd0, ss}, 32'd0);
        rst = 1'b0;
        #1;
        chk("midframe_reset", {23'd0, ss, mosi, sclk, st}, {23'd0, 1'b1, 1'b0, 1'b0, 6'd0});
        @(negedge clk);
        rst = 1'b1;
        read_cnt(v);
        chk("reset_counter", {16'd0, v}, 32'h0000);
        chk("reset_done", {31'd0, st[4]}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
